sh_mem_rr_responder: RTL and testbench
======================================

Name: sh_mem_rr_responder

Overview:
Responder end of the per-core shared-memory interface: serves LD/ST requests from NUM_CORES core memory ports against one single-port data array. A round-robin grant picks one core, performs the access, and returns a one-cycle ready pulse with read data to that core. Connects directly to the packed enable/addr/wr_data/rd_data/ready buses that the core array drives.

Parameters:
NUM_CORES, `NUM_OF_CORES, number of core ports
ENABLE_W, `ENABLE_SIZE (2), per-core request opcode width
ADDR_W, `ADDR_SIZE, per-core address width; array depth = 2**ADDR_W
DATA_W, `REG_SIZE, data word width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
enable  in  ENABLE_W*NUM_CORES  packed request opcodes, core i at [ENABLE_W*(i+1)-1 : ENABLE_W*i]
addr  in  ADDR_W*NUM_CORES  packed addresses, same slicing
wr_data  in  DATA_W*NUM_CORES  packed store data
rd_data  out  DATA_W*NUM_CORES  packed per-core read-data registers
ready  out  NUM_CORES  per-core completion pulse

Behaviour:
- Opcodes: 2'b00 idle, 2'b01 LD, 2'b10 ST, 2'b11 reserved; reserved is never granted and never acknowledged.
- Request rule: a core holds enable/addr/wr_data stable from assertion until it samples ready=1, then drives enable=00 starting the next cycle.
- FSM states IDLE, ACCESS, DONE.
- IDLE: if any core has LD/ST, grant the first requester at or after rr_ptr, searching upward modulo NUM_CORES. Latch the winner index, op, addr and wr_data, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: ST writes mem[addr] = data. LD loads mem[addr] into rd_data slice of the winner. Go to DONE.
- DONE: ready[winner]=1 for exactly this cycle. rr_ptr <= (winner+1) mod NUM_CORES. Go to IDLE.
- Latency: request visible in IDLE cycle t, ready high in cycle t+2, rd_data valid from t+2. One access per 3 cycles maximum.
- At most one ready bit is high in any cycle. ready is registered.
- rd_data slice of a core holds its last LD result until that core's next LD completes. ST leaves rd_data unchanged.
- Requests arriving in ACCESS or DONE are held by the core and arbitrated in the next IDLE.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 other grants.
- Reset (any state, including mid-access): FSM to IDLE, ready=0, rr_ptr=0, all rd_data=0, latched request discarded.
- A ST whose ACCESS cycle coincides with reset=1 does not write.
- Array contents are not cleared by reset.
- Address width equals array index width, so no out-of-range case exists.

Decomposition:
- Shared define file holds the opcode constants MEM_OP_IDLE, MEM_OP_LD, MEM_OP_ST and the existing size macros used as parameter defaults.
- One sub-module, rr_pick: combinational round-robin selector with inputs req[NUM_CORES] and ptr, and outputs valid and idx.

Test Plan:
1. After reset, core0 ST addr 8 data 3, then LD addr 8 -> ready[0] pulses 2 cycles after each request appears; rd_data core0 = 3; all other ready bits stay 0.
2. Cores 0, 1 and 2 assert ST in the same cycle with addr 1/2/3 and data 0x10/0x20/0x30 -> ready pulses in order 0,1,2, three cycles apart; later LDs return 0x10/0x20/0x30.
3. Cores 0 and 3 issue back-to-back LDs continuously -> grants alternate 0,3,0,3; neither core waits more than one foreign grant.
4. Core2 drives enable=11 for 10 cycles -> no ready[2], FSM stays IDLE, array unchanged.
5. Write mem[5]=0x11. Core1 then issues ST mem[5]=0xAA with reset=1 during its ACCESS cycle -> no ready pulse, rd_data all 0, later LD addr 5 returns 0x11.
6. Core0 LD addr 8 (value 3), then core0 ST addr 8 data 7 -> rd_data core0 stays 3 after the ST ready pulse.

Source files
------------

// File: rtl/sh_mem_rr_responder_pkg.sv
// Shared constants and types for the shared-memory round-robin responder.
package sh_mem_rr_responder_pkg;

   localparam int unsigned DEF_NUM_CORES = 4;
   localparam int unsigned DEF_ENABLE_W  = 2;
   localparam int unsigned DEF_ADDR_W    = 4;
   localparam int unsigned DEF_DATA_W    = 8;

   localparam logic [1:0] MEM_OP_IDLE = 2'b00;
   localparam logic [1:0] MEM_OP_LD   = 2'b01;
   localparam logic [1:0] MEM_OP_ST   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Width of a core index; never zero even for a single core.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sh_mem_rr_responder_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module sh_mem_rr_responder_rr_pick
   import sh_mem_rr_responder_pkg::*;
#(
   parameter int unsigned NUM_CORES = DEF_NUM_CORES,
   localparam int unsigned PTR_W = ptr_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req_i,
   input  logic [PTR_W-1:0]     ptr_i,
   output logic                 valid_o,
   output logic [PTR_W-1:0]     idx_o
);

   int unsigned      cand;
   logic [PTR_W-1:0] cand_idx;

   // Scan upward from the pointer; the first hit wins.
   always_comb begin
      valid_o  = 1'b0;
      idx_o    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= NUM_CORES) cand = cand - NUM_CORES;
         cand_idx = PTR_W'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/sh_mem_rr_responder.sv
// Responder for per-core LD/ST requests against one single-port array, round-robin arbitrated.
module sh_mem_rr_responder
   import sh_mem_rr_responder_pkg::*;
#(
   parameter int unsigned NUM_CORES = DEF_NUM_CORES,
   parameter int unsigned ENABLE_W  = DEF_ENABLE_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ENABLE_W*NUM_CORES-1:0] enable,
   input  logic [ADDR_W*NUM_CORES-1:0]   addr,
   input  logic [DATA_W*NUM_CORES-1:0]   wr_data,
   output logic [DATA_W*NUM_CORES-1:0]   rd_data,
   output logic [NUM_CORES-1:0]          ready
);

   localparam int unsigned PTR_W = ptr_width(NUM_CORES);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [ENABLE_W-1:0] op_a    [NUM_CORES];
   logic [ADDR_W-1:0]   addr_a  [NUM_CORES];
   logic [DATA_W-1:0]   wdata_a [NUM_CORES];
   logic [NUM_CORES-1:0] req_c;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    winner_q, winner_d;
   logic [ENABLE_W-1:0] op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_CORES-1:0] ready_q, ready_d;
   logic [DATA_W-1:0]   rd_q [NUM_CORES];
   logic [DATA_W-1:0]   rd_d [NUM_CORES];
   logic                mem_we_c;
   logic                pick_valid_c;
   logic [PTR_W-1:0]    pick_idx_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Unpack the per-core buses; reserved and idle opcodes are not requests.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         op_a[i]    = enable[ENABLE_W*i +: ENABLE_W];
         addr_a[i]  = addr[ADDR_W*i +: ADDR_W];
         wdata_a[i] = wr_data[DATA_W*i +: DATA_W];
         req_c[i]   = (op_a[i] == ENABLE_W'(MEM_OP_LD)) || (op_a[i] == ENABLE_W'(MEM_OP_ST));
      end
   end

   sh_mem_rr_responder_rr_pick #(
      .NUM_CORES (NUM_CORES)
   ) u_rr_pick (
      .req_i   (req_c),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid_c),
      .idx_o   (pick_idx_c)
   );

   // Next-state and datapath: grant in IDLE, access in ACCESS, advance pointer in DONE.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rr_ptr_d = rr_ptr_q;
      ready_d  = '0;
      rd_d     = rd_q;
      mem_we_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               winner_d = pick_idx_c;
               op_d     = op_a[pick_idx_c];
               addr_d   = addr_a[pick_idx_c];
               wdata_d  = wdata_a[pick_idx_c];
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (op_q == ENABLE_W'(MEM_OP_ST)) mem_we_c = 1'b1;
            else                             rd_d[winner_q] = mem[addr_q];
            ready_d[winner_q] = 1'b1;
            state_d           = ST_DONE;
         end
         ST_DONE: begin
            rr_ptr_d = (32'(winner_q) == NUM_CORES - 1) ? '0 : winner_q + PTR_W'(1);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any latched request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         winner_q <= '0;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rr_ptr_q <= '0;
         ready_q  <= '0;
         rd_q     <= '{default: '0};
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rr_ptr_q <= rr_ptr_d;
         ready_q  <= ready_d;
         rd_q     <= rd_d;
      end
   end

   // Array write; contents survive reset but a store is suppressed while reset is high.
   always_ff @(posedge clk) begin
      if (mem_we_c && !reset) mem[addr_q] <= wdata_q;
   end

   // Pack the per-core read-data registers onto the output bus.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         rd_data[DATA_W*i +: DATA_W] = rd_q[i];
      end
   end

   assign ready = ready_q;

endmodule

// File: tb/tb_sh_mem_rr_responder.sv
// Scoreboard bench for the shared-memory round-robin responder.
module tb_sh_mem_rr_responder;
   import sh_mem_rr_responder_pkg::*;

   localparam int unsigned NC = 4;
   localparam int unsigned EW = 2;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic              clk;
   logic              reset;
   logic [EW*NC-1:0]  enable;
   logic [AW*NC-1:0]  addr;
   logic [DW*NC-1:0]  wr_data;
   logic [DW*NC-1:0]  rd_data;
   logic [NC-1:0]     ready;

   sh_mem_rr_responder #(
      .NUM_CORES (NC),
      .ENABLE_W  (EW),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .ready   (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           core;
      bit           is_ld;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            grant_log[$];
   logic [DW-1:0] model_mem [1 << AW];
   logic [DW-1:0] model_rd  [NC];
   int            cyc;
   int            n_pass;
   int            n_total;
   int            issue_cyc [NC];
   int            ready_cyc [NC];
   bit            done      [NC];
   int            gap       [NC];
   bit            reissue_en[NC];
   logic [AW-1:0] reissue_addr[NC];

   // Drive one core's request; optionally record the expected completion.
   task automatic issue(input int c, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit expect_it);
      exp_t e;
      enable[c*EW +: EW]  = op;
      addr[c*AW +: AW]    = a;
      wr_data[c*DW +: DW] = d;
      issue_cyc[c] = cyc;
      done[c]      = 1'b0;
      if (expect_it) begin
         e.core  = c;
         e.is_ld = (op == MEM_OP_LD);
         e.data  = (op == MEM_OP_LD) ? model_mem[a] : d;
         if (op == MEM_OP_ST) model_mem[a] = d;
         sb.push_back(e);
      end
   endtask

   // Advance one cycle, act as the cores, and score any completion.
   task automatic step();
      exp_t              e;
      int                found;
      logic [DW*NC-1:0]  exp_rd;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
         if (gap[c] > 0) begin
            gap[c]--;
            if (gap[c] == 0 && reissue_en[c]) issue(c, MEM_OP_LD, reissue_addr[c], '0, 1'b1);
         end
      end
      if (ready !== '0) begin
         n_total++;
         if ($countones(ready) == 1) n_pass++;
         else $display("FAIL onehot_ready: ready=%b required exactly one bit set", ready);
         for (int c = 0; c < NC; c++) begin
            if (ready[c] === 1'b1) begin
               ready_cyc[c] = cyc;
               done[c]      = 1'b1;
               grant_log.push_back(c);
               enable[c*EW +: EW] = MEM_OP_IDLE;
               gap[c] = 2;
               found  = -1;
               for (int k = 0; k < sb.size(); k++) begin
                  if (found < 0 && sb[k].core == c) found = k;
               end
               n_total++;
               if (found < 0) begin
                  $display("FAIL sb_expected_ready: core %0d pulsed ready at cycle %0d, required no pulse", c, cyc);
               end else begin
                  e = sb[found];
                  sb.delete(found);
                  if (e.is_ld) model_rd[c] = e.data;
                  n_pass++;
               end
            end
         end
         for (int c = 0; c < NC; c++) exp_rd[c*DW +: DW] = model_rd[c];
         n_total++;
         if (rd_data !== exp_rd) $display("FAIL sb_rd_data: rd_data=%h required %h", rd_data, exp_rd);
         else n_pass++;
      end
   endtask

   task automatic wait_done(input int c, input int budget);
      int n;
      n = 0;
      while (!done[c] && n < budget) begin
         step();
         n++;
      end
      n_total++;
      if (done[c]) n_pass++;
      else $display("FAIL timeout_core%0d: ready not seen after %0d cycles, required a pulse", c, budget);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      enable  = '0;
      addr    = '0;
      wr_data = '0;
      step();
      step();
      reset = 1'b0;
      sb.delete();
      for (int c = 0; c < NC; c++) begin
         model_rd[c]   = '0;
         gap[c]        = 0;
         reissue_en[c] = 1'b0;
         done[c]       = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (ready !== '0) $display("FAIL reset_ready: ready=%b required 0", ready);
      else n_pass++;
      n_total++;
      if (rd_data !== '0) $display("FAIL reset_rd_data: rd_data=%h required 0", rd_data);
      else n_pass++;
   endtask

   task automatic test_st_ld();
      issue(0, MEM_OP_ST, 4'd8, 8'h03, 1'b1);
      wait_done(0, 10);
      n_total++;
      if (ready_cyc[0] - issue_cyc[0] != 2)
         $display("FAIL st_latency: latency=%0d required 2", ready_cyc[0] - issue_cyc[0]);
      else n_pass++;
      step();
      issue(0, MEM_OP_LD, 4'd8, '0, 1'b1);
      wait_done(0, 10);
      n_total++;
      if (ready_cyc[0] - issue_cyc[0] != 2)
         $display("FAIL ld_latency: latency=%0d required 2", ready_cyc[0] - issue_cyc[0]);
      else n_pass++;
      n_total++;
      if (rd_data[0 +: DW] !== 8'h03) $display("FAIL ld_data_core0: got %h required 03", rd_data[0 +: DW]);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      issue(0, MEM_OP_ST, 4'd1, 8'h10, 1'b1);
      issue(1, MEM_OP_ST, 4'd2, 8'h20, 1'b1);
      issue(2, MEM_OP_ST, 4'd3, 8'h30, 1'b1);
      wait_done(2, 20);
      n_total++;
      if (ready_cyc[0] - issue_cyc[0] != 2)
         $display("FAIL simul_first: latency=%0d required 2", ready_cyc[0] - issue_cyc[0]);
      else n_pass++;
      n_total++;
      if (ready_cyc[1] - ready_cyc[0] != 3)
         $display("FAIL simul_gap01: gap=%0d required 3", ready_cyc[1] - ready_cyc[0]);
      else n_pass++;
      n_total++;
      if (ready_cyc[2] - ready_cyc[1] != 3)
         $display("FAIL simul_gap12: gap=%0d required 3", ready_cyc[2] - ready_cyc[1]);
      else n_pass++;
      step();
      issue(0, MEM_OP_LD, 4'd1, '0, 1'b1);
      issue(1, MEM_OP_LD, 4'd2, '0, 1'b1);
      issue(2, MEM_OP_LD, 4'd3, '0, 1'b1);
      for (int c = 0; c < 3; c++) wait_done(c, 20);
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      grant_log.delete();
      reissue_en[0] = 1'b1;  reissue_addr[0] = 4'd1;
      reissue_en[3] = 1'b1;  reissue_addr[3] = 4'd3;
      issue(0, MEM_OP_LD, 4'd1, '0, 1'b1);
      issue(3, MEM_OP_LD, 4'd3, '0, 1'b1);
      n = 0;
      while (grant_log.size() < 8 && n < 60) begin
         step();
         n++;
      end
      reissue_en[0] = 1'b0;
      reissue_en[3] = 1'b0;
      n_total++;
      if (grant_log.size() < 8) $display("FAIL b2b_grants: saw %0d grants required 8", grant_log.size());
      else n_pass++;
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
         n_total++;
         if (grant_log[i] != ((i % 2 == 0) ? 0 : 3))
            $display("FAIL b2b_order%0d: core %0d required %0d", i, grant_log[i], (i % 2 == 0) ? 0 : 3);
         else n_pass++;
      end
      n = 0;
      while (sb.size() > 0 && n < 30) begin
         step();
         n++;
      end
      n_total++;
      if (sb.size() != 0) $display("FAIL b2b_drain: %0d outstanding required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_reserved();
      grant_log.delete();
      issue(2, 2'b11, 4'd1, 8'hEE, 1'b0);
      for (int i = 0; i < 10; i++) step();
      n_total++;
      if (grant_log.size() != 0) $display("FAIL reserved_grant: %0d grants required 0", grant_log.size());
      else n_pass++;
      enable[2*EW +: EW] = MEM_OP_IDLE;
      issue(0, MEM_OP_LD, 4'd1, '0, 1'b1);
      wait_done(0, 10);
      n_total++;
      if (ready_cyc[0] - issue_cyc[0] != 2)
         $display("FAIL reserved_idle_latency: latency=%0d required 2", ready_cyc[0] - issue_cyc[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_access();
      issue(0, MEM_OP_ST, 4'd5, 8'h11, 1'b1);
      wait_done(0, 10);
      step();
      issue(1, MEM_OP_ST, 4'd5, 8'hAA, 1'b0);
      step();
      reset  = 1'b1;
      enable = '0;
      step();
      n_total++;
      if (ready !== '0) $display("FAIL midreset_ready: ready=%b required 0", ready);
      else n_pass++;
      n_total++;
      if (rd_data !== '0) $display("FAIL midreset_rd_data: rd_data=%h required 0", rd_data);
      else n_pass++;
      reset = 1'b0;
      sb.delete();
      for (int c = 0; c < NC; c++) begin
         model_rd[c] = '0;
         gap[c]      = 0;
      end
      for (int i = 0; i < 4; i++) step();
      issue(1, MEM_OP_LD, 4'd5, '0, 1'b1);
      wait_done(1, 10);
      n_total++;
      if (rd_data[DW +: DW] !== 8'h11) $display("FAIL midreset_array: got %h required 11", rd_data[DW +: DW]);
      else n_pass++;
   endtask

   task automatic test_st_keeps_rd();
      step();
      issue(0, MEM_OP_LD, 4'd8, '0, 1'b1);
      wait_done(0, 10);
      step();
      issue(0, MEM_OP_ST, 4'd8, 8'h07, 1'b1);
      wait_done(0, 10);
      n_total++;
      if (rd_data[0 +: DW] !== 8'h03) $display("FAIL st_keeps_rd: got %h required 03", rd_data[0 +: DW]);
      else n_pass++;
   endtask

   initial begin
      reset   = 1'b1;
      enable  = '0;
      addr    = '0;
      wr_data = '0;
      cyc     = 0;
      n_pass  = 0;
      n_total = 0;
      for (int c = 0; c < NC; c++) begin
         issue_cyc[c] = 0;
         ready_cyc[c] = 0;
         model_rd[c]  = '0;
      end
      for (int a = 0; a < (1 << AW); a++) model_mem[a] = '0;
      test_reset();
      test_st_ld();
      test_simultaneous();
      test_back_to_back();
      test_reserved();
      test_reset_mid_access();
      test_st_keeps_rd();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
